// File: rtl/wordle_game_ctrl.sv
// Wordle game sequencer: assembles 5-letter guesses from key pulses, hands them to the
// combinational colour engine, writes scored rows to history and tracks win/lose.
module wordle_game_ctrl #(
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned LETTER_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         new_game,
  input  logic [WORD_LEN*LETTER_W-1:0] answer,
  input  logic                         letter_valid,
  input  logic [LETTER_W-1:0]          letter_code,
  input  logic                         backspace,
  input  logic                         submit,
  output logic [WORD_LEN*LETTER_W-1:0] guess_word,
  output logic [WORD_LEN*LETTER_W-1:0] chosen_word,
  input  logic [WORD_LEN-1:0]          greens_in,
  input  logic [WORD_LEN-1:0]          yellows_in,
  output logic [WORD_LEN*LETTER_W-1:0] cur_word,
  output logic [2:0]                   cur_len,
  output logic [2:0]                   guess_idx,
  output logic                         row_we,
  output logic [2:0]                   row_idx,
  output logic [WORD_LEN*LETTER_W-1:0] row_word,
  output logic [WORD_LEN-1:0]          row_greens,
  output logic [WORD_LEN-1:0]          row_yellows,
  output logic                         reject,
  output logic                         playing,
  output logic                         won,
  output logic                         lost
);
  localparam int unsigned WordW = WORD_LEN * LETTER_W;

  typedef enum logic [2:0] {StIdle, StEntry, StEval, StWrite, StWon, StLost} state_e;

  state_e state_q, state_d;

  logic [WordW-1:0]    cur_word_q, cur_word_d, guess_word_q, guess_word_d;
  logic [WordW-1:0]    chosen_q, chosen_d, row_word_q, row_word_d;
  logic [2:0]          cur_len_q, cur_len_d, guess_idx_q, guess_idx_d, row_idx_q, row_idx_d;
  logic [WORD_LEN-1:0] greens_q, greens_d, yellows_q, yellows_d;
  logic                row_we_q, row_we_d, reject_q, reject_d;
  logic                playing_q, playing_d, won_q, won_d, lost_q, lost_d;
  logic                code_legal, all_green, last_row, any_action;
  logic [2:0]          len_m1;

  assign code_legal = (letter_code != '0) && (letter_code <= LETTER_W'(26));
  assign all_green  = (greens_q == {WORD_LEN{1'b1}});
  assign last_row   = (guess_idx_q == 3'(MAX_GUESSES - 1));
  assign any_action = letter_valid | backspace | submit;
  assign len_m1     = cur_len_q - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = StEntry;
    end else begin
      case (state_q)
        StEntry: if (submit && cur_len_q == 3'(WORD_LEN)) state_d = StEval;
        StEval:  state_d = StWrite;
        StWrite: begin
          if (all_green)     state_d = StWon;
          else if (last_row) state_d = StLost;
          else               state_d = StEntry;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cur_word_d   = cur_word_q;
    cur_len_d    = cur_len_q;
    guess_word_d = guess_word_q;
    guess_idx_d  = guess_idx_q;
    chosen_d     = chosen_q;
    greens_d     = greens_q;
    yellows_d    = yellows_q;
    row_word_d   = row_word_q;
    row_idx_d    = row_idx_q;
    reject_d     = 1'b0;
    if (new_game) begin
      chosen_d     = answer;
      guess_idx_d  = '0;
      cur_word_d   = '0;
      cur_len_d    = '0;
      guess_word_d = '0;
    end else begin
      case (state_q)
        StEntry: begin
          // One action per cycle; lower-priority pulses in the same cycle are dropped.
          if (submit) begin
            if (cur_len_q == 3'(WORD_LEN)) guess_word_d = cur_word_q;
            else                           reject_d     = 1'b1;
          end else if (backspace) begin
            if (cur_len_q != '0) begin
              for (int i = 0; i < int'(WORD_LEN); i++) begin
                if (len_m1 == i[2:0]) cur_word_d[(int'(WORD_LEN) - 1 - i) * LETTER_W +: LETTER_W] = '0;
              end
              cur_len_d = len_m1;
            end else begin
              reject_d = 1'b1;
            end
          end else if (letter_valid) begin
            if (cur_len_q < 3'(WORD_LEN) && code_legal) begin
              for (int i = 0; i < int'(WORD_LEN); i++) begin
                if (cur_len_q == i[2:0]) begin
                  cur_word_d[(int'(WORD_LEN) - 1 - i) * LETTER_W +: LETTER_W] = letter_code;
                end
              end
              cur_len_d = cur_len_q + 3'd1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        StEval: begin
          greens_d   = greens_in;
          yellows_d  = yellows_in;
          row_word_d = guess_word_q;
          row_idx_d  = guess_idx_q;
          reject_d   = any_action;
        end
        StWrite: begin
          reject_d = any_action;
          if (!all_green && !last_row) begin
            guess_idx_d = guess_idx_q + 3'd1;
            cur_word_d  = '0;
            cur_len_d   = '0;
          end
        end
        default: ;
      endcase
    end
    row_we_d  = (state_d == StWrite);
    playing_d = (state_d == StEntry) || (state_d == StEval) || (state_d == StWrite);
    won_d     = (state_d == StWon);
    lost_d    = (state_d == StLost);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_word_q   <= '0;
      cur_len_q    <= '0;
      guess_word_q <= '0;
      guess_idx_q  <= '0;
      chosen_q     <= '0;
      greens_q     <= '0;
      yellows_q    <= '0;
      row_word_q   <= '0;
      row_idx_q    <= '0;
      row_we_q     <= 1'b0;
      reject_q     <= 1'b0;
      playing_q    <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      cur_word_q   <= cur_word_d;
      cur_len_q    <= cur_len_d;
      guess_word_q <= guess_word_d;
      guess_idx_q  <= guess_idx_d;
      chosen_q     <= chosen_d;
      greens_q     <= greens_d;
      yellows_q    <= yellows_d;
      row_word_q   <= row_word_d;
      row_idx_q    <= row_idx_d;
      row_we_q     <= row_we_d;
      reject_q     <= reject_d;
      playing_q    <= playing_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
    end
  end

  assign guess_word  = guess_word_q;
  assign chosen_word = chosen_q;
  assign cur_word    = cur_word_q;
  assign cur_len     = cur_len_q;
  assign guess_idx   = guess_idx_q;
  assign row_we      = row_we_q;
  assign row_idx     = row_idx_q;
  assign row_word    = row_word_q;
  assign row_greens  = greens_q;
  assign row_yellows = yellows_q;
  assign reject      = reject_q;
  assign playing     = playing_q;
  assign won         = won_q;
  assign lost        = lost_q;
endmodule
